// File: rtl/acc_cpu_controller.sv
// acc_cpu_controller
//   Multi-cycle sequencer for the accumulator CPU. It holds PC and IR and
//   steps each instruction through FETCH -> DECODE -> (EXEC) -> FETCH. It
//   drives the shared memory address and enables, and the accumulator/ALU
//   controls. Memory reads are combinational, so IR is captured in the
//   FETCH cycle itself.
//
//   Every output is registered. Each output register is loaded with the
//   value that belongs to the state being entered, so an output is valid
//   during the whole cycle of that state. Reset clears the outputs at once.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             level; begins execution from PC=0 in IDLE or HALT
//   ac_zero           accumulator==0 flag from the datapath
//   instr_rdata       instruction store read data (combinational)
//   mem_addr          shared address bus to the memory block
//   instr_rd_en       instruction read enable (FETCH)
//   data_rd_en        data read enable (LOAD/ADD/SUB/AND in EXEC)
//   data_wr_en        data write enable (STORE in EXEC)
//   ac_ld, ac_src     accumulator load strobe / source (1 = immediate)
//   alu_op            00 PASS, 01 ADD, 10 SUB, 11 AND
//   imm               IR operand field
//   pc, state_dbg     current PC and encoded state
//   halted, error     HALT indicator, sticky fault flag
module acc_cpu_controller #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int INSTR_DEPTH = 12,
  parameter int DATA_DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ac_zero,
  input  logic [DATA_W-1:0] instr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              instr_rd_en,
  output logic              data_rd_en,
  output logic              data_wr_en,
  output logic              ac_ld,
  output logic              ac_src,
  output logic [1:0]        alu_op,
  output logic [ADDR_W-1:0] imm,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state_dbg,
  output logic              halted,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_JMP   = 4'b0011;
  localparam logic [3:0] OP_JZ    = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_LOADI = 4'b1000;

  // The limits are one bit wider than the address, so a depth of 2**ADDR_W still fits.
  localparam logic [ADDR_W:0]   INSTR_LIM = (ADDR_W+1)'(INSTR_DEPTH);
  localparam logic [ADDR_W:0]   DATA_LIM  = (ADDR_W+1)'(DATA_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(INSTR_DEPTH - 1);

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              jump_ok;
  logic              data_ok;

  assign opcode    = ir[DATA_W-1 -: 4];
  assign operand   = ir[ADDR_W-1:0];
  assign jump_ok   = {1'b0, operand} < INSTR_LIM;
  assign data_ok   = {1'b0, operand} < DATA_LIM;
  assign pc_inc    = (pc_reg == LAST_PC) ? '0 : pc_reg + 1'b1;
  assign imm       = operand;
  assign pc        = pc_reg;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ir          <= '0;
      pc_reg      <= '0;
      mem_addr    <= '0;
      instr_rd_en <= 1'b0;
      data_rd_en  <= 1'b0;
      data_wr_en  <= 1'b0;
      ac_ld       <= 1'b0;
      ac_src      <= 1'b0;
      alu_op      <= 2'b00;
      halted      <= 1'b0;
      error       <= 1'b0;
    end else begin
      // All strobes default low, so each one lasts exactly one cycle.
      mem_addr    <= '0;
      instr_rd_en <= 1'b0;
      data_rd_en  <= 1'b0;
      data_wr_en  <= 1'b0;
      ac_ld       <= 1'b0;
      ac_src      <= 1'b0;
      alu_op      <= 2'b00;

      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_reg      <= '0;
            halted      <= 1'b0;
            state       <= S_FETCH;
            instr_rd_en <= 1'b1;
          end
        end

        S_FETCH: begin
          ir     <= instr_rdata;
          pc_reg <= pc_inc;
          state  <= S_DECODE;
        end

        S_DECODE: begin
          case (opcode)
            OP_HALT: begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
            OP_JMP, OP_JZ: begin
              if (opcode == OP_JZ && !ac_zero) begin
                // A JZ that is not taken simply falls through to the next PC.
                state       <= S_FETCH;
                instr_rd_en <= 1'b1;
                mem_addr    <= pc_reg;
              end else if (jump_ok) begin
                pc_reg      <= operand;
                state       <= S_FETCH;
                instr_rd_en <= 1'b1;
                mem_addr    <= operand;
              end else begin
                state <= S_ERROR;
                error <= 1'b1;
              end
            end
            OP_LOADI: begin
              state    <= S_EXEC;
              mem_addr <= operand;
              ac_ld    <= 1'b1;
              ac_src   <= 1'b1;
            end
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: begin
              // An out-of-range operand faults here, before any data enable is raised.
              if (data_ok) begin
                state    <= S_EXEC;
                mem_addr <= operand;
                if (opcode == OP_STORE) begin
                  data_wr_en <= 1'b1;
                end else begin
                  data_rd_en <= 1'b1;
                  ac_ld      <= 1'b1;
                  case (opcode)
                    OP_ADD:  alu_op <= 2'b01;
                    OP_SUB:  alu_op <= 2'b10;
                    OP_AND:  alu_op <= 2'b11;
                    default: alu_op <= 2'b00;
                  endcase
                end
              end else begin
                state <= S_ERROR;
                error <= 1'b1;
              end
            end
            default: begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          endcase
        end

        S_EXEC: begin
          state       <= S_FETCH;
          instr_rd_en <= 1'b1;
          mem_addr    <= pc_reg;
        end

        S_ERROR: begin
          error <= 1'b1;
        end

        default: begin
          state <= S_ERROR;
          error <= 1'b1;
        end
      endcase
    end
  end

endmodule
